// File: rtl/oh_powergate_ctrl.sv
// Power-gating sequencer for a switched domain: staged footer turn-on, retention
// restore/save pulses, isolation control and a single-step power-down.
module oh_powergate_ctrl #(
  parameter int N  = 4,  // staged footer switch segments, 2..32
  parameter int DW = 8   // width of the stage delay configuration
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pwr_req,
  input  logic [DW-1:0] cfg_delay,
  output logic [N-1:0]  nsleep,
  output logic          iso_en,
  output logic          ret_save,
  output logic          ret_restore,
  output logic          pwr_ack,
  output logic          busy,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    StOff     = 3'd0,
    StPwrUp   = 3'd1,
    StRestore = 3'd2,
    StOn      = 3'd3,
    StIso     = 3'd4,
    StSave    = 3'd5,
    StPwrDn   = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic          pwr_req_q;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [N-1:0]  nsleep_q, nsleep_d;
  logic          iso_en_q, iso_en_d;
  logic          ret_save_q, ret_save_d;
  logic          ret_restore_q, ret_restore_d;
  logic          pwr_ack_q, pwr_ack_d;
  logic          busy_q, busy_d;

  // Next-state, stage counter, latched delay and footer enables.
  // The request is taken from its registered copy so no input reaches an output
  // combinationally; this adds one cycle between sampling and the transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    dly_d    = dly_q;
    nsleep_d = nsleep_q;
    case (state_q)
      StOff: begin
        nsleep_d = '0;
        if (pwr_req_q) begin
          state_d = StPwrUp;
          dly_d   = cfg_delay;
        end
      end
      StPwrUp: begin
        if (cnt_q == dly_q) begin
          if (&nsleep_q) begin
            state_d = StRestore;
          end else begin
            nsleep_d = {nsleep_q[N-2:0], 1'b1};
          end
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      StRestore: state_d = StOn;
      StOn: begin
        nsleep_d = '1;
        if (!pwr_req_q) state_d = StIso;
      end
      StIso: state_d = StSave;
      StSave: begin
        dly_d    = cfg_delay;
        nsleep_d = '0;  // all segments drop together on entry to power-down
        state_d  = StPwrDn;
      end
      StPwrDn: begin
        nsleep_d = '0;
        if (cnt_q == dly_q) begin
          state_d = StOff;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: begin
        // Unused encoding recovers to OFF.
        state_d  = StOff;
        nsleep_d = '0;
      end
    endcase
  end

  // Registered status outputs, decoded from the upcoming state.
  always_comb begin
    iso_en_d      = (state_d != StOn);
    pwr_ack_d     = (state_d == StOn);
    busy_d        = (state_d != StOn) && (state_d != StOff);
    ret_save_d    = (state_d == StSave);
    ret_restore_d = (state_d == StRestore);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StOff;
      pwr_req_q     <= 1'b0;
      cnt_q         <= '0;
      dly_q         <= '0;
      nsleep_q      <= '0;
      iso_en_q      <= 1'b1;
      ret_save_q    <= 1'b0;
      ret_restore_q <= 1'b0;
      pwr_ack_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pwr_req_q     <= pwr_req;
      cnt_q         <= cnt_d;
      dly_q         <= dly_d;
      nsleep_q      <= nsleep_d;
      iso_en_q      <= iso_en_d;
      ret_save_q    <= ret_save_d;
      ret_restore_q <= ret_restore_d;
      pwr_ack_q     <= pwr_ack_d;
      busy_q        <= busy_d;
    end
  end

  assign state       = state_q;
  assign nsleep      = nsleep_q;
  assign iso_en      = iso_en_q;
  assign ret_save    = ret_save_q;
  assign ret_restore = ret_restore_q;
  assign pwr_ack     = pwr_ack_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_oh_powergate_ctrl.sv
// Bench for oh_powergate_ctrl: directed sequences plus random requests, delays and
// resets, checked each cycle against a timeline model built from the latency rules.
module tb_oh_powergate_ctrl;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pwr_req = 1'b0;
  logic [DW-1:0] cfg_delay = '0;
  logic [N-1:0]  nsleep;
  logic          iso_en, ret_save, ret_restore, pwr_ack, busy;
  logic [2:0]    state;

  oh_powergate_ctrl #(.N(N), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .pwr_req     (pwr_req),
    .cfg_delay   (cfg_delay),
    .nsleep      (nsleep),
    .iso_en      (iso_en),
    .ret_save    (ret_save),
    .ret_restore (ret_restore),
    .pwr_ack     (pwr_ack),
    .busy        (busy),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Model: mode plus the edge at which the governing request was sampled.
  typedef enum int {MOff, MUp, MOn, MDn} mode_e;
  mode_e m_mode = MOff;
  int    m_ts   = 0;
  int    m_dl   = 0;
  bit    m_pend = 1'b0;
  int    e      = 0;

  int         n_checks = 0;
  int         n_errs   = 0;
  logic [N-1:0] prev_ns = '0;
  logic [2:0]   prev_st = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  // Segments on so far: segment k is on from edge ts+1+(k+1)(D+1).
  function automatic logic [N-1:0] exp_ns_up();
    logic [N-1:0] v = '0;
    for (int k = 0; k < N; k++) begin
      if (e >= m_ts + 1 + (k + 1) * (m_dl + 1)) v[k] = 1'b1;
    end
    return v;
  endfunction

  task automatic model_edge(input logic rst, input logic req, input int cfg);
    e++;
    if (rst) begin
      m_mode = MOff;
      m_pend = 1'b0;
    end else begin
      if (m_pend && e == m_ts + 1) begin
        m_pend = 1'b0;
        if (m_mode == MOff) begin
          m_mode = MUp;
          m_dl   = cfg;
        end else begin
          m_mode = MDn;
        end
      end else if (m_mode == MUp && e == m_ts + 2 + (N + 1) * (m_dl + 1)) begin
        m_mode = MOn;
      end else if (m_mode == MDn) begin
        if (e == m_ts + 3) m_dl = cfg;
        if (e == m_ts + 4 + m_dl) m_mode = MOff;
      end
      if (!m_pend && ((m_mode == MOff && req) || (m_mode == MOn && !req))) begin
        m_pend = 1'b1;
        m_ts   = e;
      end
    end
  endtask

  task automatic check_outputs();
    logic [2:0]   es;
    logic [N-1:0] ens;
    logic         eiso, eack, ebusy, esave, erest;
    int           tr;
    es = 3'd0; ens = '0; eiso = 1'b1; eack = 1'b0; ebusy = 1'b0;
    esave = 1'b0; erest = 1'b0;
    case (m_mode)
      MUp: begin
        tr    = m_ts + 1 + (N + 1) * (m_dl + 1);
        ens   = exp_ns_up();
        es    = (e == tr) ? 3'd2 : 3'd1;
        erest = (e == tr);
        ebusy = 1'b1;
      end
      MOn: begin
        es = 3'd3; ens = '1; eiso = 1'b0; eack = 1'b1;
      end
      MDn: begin
        ebusy = 1'b1;
        if (e == m_ts + 1) begin
          es = 3'd4; ens = '1;
        end else if (e == m_ts + 2) begin
          es = 3'd5; ens = '1; esave = 1'b1;
        end else begin
          es = 3'd6; ens = '0;
        end
      end
      default: ;
    endcase
    check("state", 32'(state), 32'(es));
    check("nsleep", 32'(nsleep), 32'(ens));
    check("iso_en", 32'(iso_en), 32'(eiso));
    check("pwr_ack", 32'(pwr_ack), 32'(eack));
    check("busy", 32'(busy), 32'(ebusy));
    check("ret_save", 32'(ret_save), 32'(esave));
    check("ret_restore", 32'(ret_restore), 32'(erest));
    // Invariants.
    check("save_and_restore", 32'(ret_save & ret_restore), 32'd0);
    check("iso_when_gated", 32'((~&nsleep) & ~iso_en), 32'd0);
    check("nsleep_fall_in_pwrup",
          32'((state == 3'd1 && prev_st == 3'd1) ? (prev_ns & ~nsleep) : '0), 32'd0);
    prev_ns = nsleep;
    prev_st = state;
  endtask

  task automatic step(input logic rst, input logic req, input int cfg);
    @(negedge clk);
    reset     = rst;
    pwr_req   = req;
    cfg_delay = DW'(cfg);
    @(posedge clk);
    model_edge(rst, req, cfg);
    #1;
    check_outputs();
  endtask

  initial begin
    logic r_req;
    int   r_cfg;
    // Reset.
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    // Power up with delay 2, then down.
    for (int i = 0; i < 22; i++) step(1'b0, 1'b1, 2);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 2);
    // Zero delay up/down.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 0);
    // Request toggles and delay changes mid power-up are ignored.
    step(1'b0, 1'b1, 3);
    step(1'b0, 1'b1, 3);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 5);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 4);
    // Reset while two segments are on, then restart.
    for (int i = 0; i < 60; i++) begin
      if (m_mode == MUp && exp_ns_up() == N'(3)) break;
      step(1'b0, 1'b1, 2);
    end
    check("reached_nsleep_0011", 32'(nsleep), 32'd3);
    step(1'b1, 1'b1, 2);
    for (int i = 0; i < 22; i++) step(1'b0, 1'b1, 2);
    // Random traffic.
    r_req = 1'b0;
    r_cfg = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) r_req = ~r_req;
      if ($urandom_range(2) == 0) r_cfg = int'($urandom_range(4));
      step(($urandom_range(249) == 0), r_req, r_cfg);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
